// File: rtl/final_mss_pkg.sv
// final_mss_pkg: shared opcodes, response codes, parser state encoding and baud helper
package final_mss_pkg;

  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_G = 8'h47;
  localparam logic [7:0] OP_A = 8'h41;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/final_mss_uart.sv
// final_mss_uart: 8N1 UART receiver and transmitter with byte valid/ready handshakes
module final_mss_uart #(
  parameter int DIV = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       txd_o
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);
  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BRK   = 3'd4;

  logic [1:0]    sync_q;
  logic [2:0]    rx_st_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic          rx;
  logic          busy_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_n_q;
  logic [9:0]    tx_sh_q;

  assign rx = sync_q[1];
  assign txd_o = tx_sh_q[0];
  assign tx_ready_o = !busy_q || (tx_n_q == 4'd9 && tx_cnt_q == LAST);

  // two-flop synchronizer on the serial input, idle high
  always_ff @(posedge clk) begin
    sync_q <= rst ? 2'b11 : {sync_q[0], rxd_i};
  end

  // receiver: mid-bit sampling; a low stop bit parks in RX_BRK until the line is high for a full bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
    end else begin
      rx_valid_o <= 1'b0;
      rx_cnt_q   <= rx_cnt_q + 1'b1;
      case (rx_st_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx) rx_st_q <= RX_START;
        end
        RX_START: if (rx_cnt_q == HALF) begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          rx_st_q  <= rx ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_cnt_q == LAST) begin
          rx_cnt_q <= '0;
          rx_sh_q  <= {rx, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
        end
        RX_STOP: if (rx_cnt_q == LAST) begin
          rx_cnt_q   <= '0;
          rx_st_q    <= rx ? RX_IDLE : RX_BRK;
          rx_valid_o <= rx;
          rx_data_o  <= rx_sh_q;
        end
        default: begin
          rx_cnt_q <= rx ? rx_cnt_q + 1'b1 : '0;
          if (rx && rx_cnt_q == LAST) rx_st_q <= RX_IDLE;
        end
      endcase
    end
  end

  // transmitter: reloads on the final stop-bit cycle so queued bytes go out with no idle gap
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      tx_sh_q  <= '1;
      tx_cnt_q <= '0;
      tx_n_q   <= '0;
    end else if (tx_valid_i && tx_ready_o) begin
      busy_q   <= 1'b1;
      tx_sh_q  <= {1'b1, tx_data_i, 1'b0};
      tx_cnt_q <= '0;
      tx_n_q   <= '0;
    end else if (busy_q) begin
      tx_cnt_q <= tx_cnt_q == LAST ? '0 : tx_cnt_q + 1'b1;
      if (tx_cnt_q == LAST) begin
        tx_sh_q <= {1'b1, tx_sh_q[9:1]};
        tx_n_q  <= tx_n_q + 1'b1;
        busy_q  <= tx_n_q != 4'd9;
      end
    end
  end

endmodule

// File: rtl/final_mss_core.sv
// final_mss_core: UART command interpreter mastering a 32-bit APB3 bus, plus fabric clock/reset/GPIO glue
module final_mss_core
  import final_mss_pkg::*;
#(
  parameter int CLK_HZ      = 10_000_000,
  parameter int BAUD        = 115_200,
  parameter int APB_TIMEOUT = 256
) (
  input  logic        SYSCLK,
  input  logic        MSS_RESET,
  output logic        MSSPSEL,
  output logic        MSSPENABLE,
  output logic        MSSPWRITE,
  output logic [19:0] MSSPADDR,
  output logic [31:0] MSSPWDATA,
  input  logic        MSSPREADY,
  input  logic        MSSPSLVERR,
  input  logic [31:0] MSSPRDATA,
  input  logic        UART_0_RXD,
  output logic        UART_0_TXD,
  input  logic        UART_1_RXD,
  output logic        UART_1_TXD,
  input  logic        ADCDirectInput_0,
  input  logic        VAREF1,
  output logic        M2F_RESET_N,
  output logic        FAB_CLK,
  output logic        GPIO_15_OUT
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam logic [15:0] GAP_LIM = 16'(16 * DIV);
  localparam int TW = $clog2(APB_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(APB_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [7:0]    op_q;
  logic [2:0]    idx_q;
  logic [43:0]   buf_q;
  logic [19:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [39:0]   resp_q;
  logic [2:0]    n_q;
  logic [15:0]   gap_q;
  logic [TW-1:0] to_q;
  logic          gpio_q;
  logic          m2f_q;
  logic [1:0]    u1_q;
  logic [1:0]    adc_q;
  logic [7:0]    rx_b;
  logic          rx_v;
  logic          tx_v;
  logic          tx_rdy;
  logic          last;
  logic          is_op;
  logic          rd_ok;
  logic          unused;

  assign FAB_CLK     = SYSCLK;
  assign M2F_RESET_N = m2f_q;
  assign GPIO_15_OUT = gpio_q;
  assign UART_1_TXD  = u1_q[1];
  assign unused      = VAREF1;
  assign is_op = rx_b == OP_W || rx_b == OP_R || rx_b == OP_G;
  assign last  = idx_q == (op_q == OP_W ? 3'd6 : op_q == OP_R ? 3'd2 : 3'd0);
  assign rd_ok = MSSPREADY && !MSSPSLVERR && op_q == OP_R;

  final_mss_uart #(.DIV(DIV)) u_uart0 (
    .clk       (SYSCLK),
    .rst       (MSS_RESET),
    .rxd_i     (UART_0_RXD),
    .rx_data_o (rx_b),
    .rx_valid_o(rx_v),
    .tx_data_i (resp_q[39:32]),
    .tx_valid_i(tx_v),
    .tx_ready_o(tx_rdy),
    .txd_o     (UART_0_TXD)
  );

  // fabric reset release, UART_1 loopback and ADC comparator synchronizers
  always_ff @(posedge SYSCLK) begin
    if (MSS_RESET) begin
      m2f_q <= 1'b0;
      u1_q  <= 2'b11;
      adc_q <= 2'b00;
    end else begin
      m2f_q <= 1'b1;
      u1_q  <= {u1_q[0], UART_1_RXD};
      adc_q <= {adc_q[0], ADCDirectInput_0};
    end
  end

  // parser / APB state register
  always_ff @(posedge SYSCLK) begin
    state_q <= MSS_RESET ? ST_IDLE : state_d;
  end

  // next state: bytes are only consumed in IDLE and COLLECT, everything else ignores RX
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (rx_v) state_d = rx_b == OP_A ? ST_RESP : is_op ? ST_COLLECT : ST_IDLE;
      ST_COLLECT: if (rx_v && last) state_d = op_q == OP_G ? ST_RESP : ST_SETUP;
                  else if (gap_q == GAP_LIM) state_d = ST_IDLE;
      ST_SETUP:   state_d = ST_ACCESS;
      ST_ACCESS:  if (MSSPREADY || to_q == TO_LAST) state_d = ST_RESP;
      ST_RESP:    if (tx_rdy && n_q == 3'd1) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // APB and response strobes decoded from state; address/data are forced to zero outside a transfer
  always_comb begin
    MSSPSEL    = state_q == ST_SETUP || state_q == ST_ACCESS;
    MSSPENABLE = state_q == ST_ACCESS;
    MSSPWRITE  = MSSPSEL && op_q == OP_W;
    MSSPADDR   = MSSPSEL ? addr_q : '0;
    MSSPWDATA  = MSSPWRITE ? wdata_q : '0;
    tx_v       = state_q == ST_RESP;
  end

  // frame assembly, gap/timeout counters and the response byte queue (MSB byte sent first)
  always_ff @(posedge SYSCLK) begin
    if (MSS_RESET) begin
      op_q    <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      n_q     <= '0;
      gap_q   <= '0;
      to_q    <= '0;
      gpio_q  <= 1'b0;
    end else begin
      gap_q <= (state_q == ST_COLLECT && !rx_v) ? gap_q + 1'b1 : '0;
      to_q  <= state_q == ST_ACCESS ? to_q + 1'b1 : '0;
      if (state_q == ST_IDLE && rx_v) begin
        op_q   <= rx_b;
        idx_q  <= '0;
        resp_q <= {7'b0, adc_q[1], 32'b0};
        n_q    <= 3'd1;
      end
      if (state_q == ST_COLLECT && rx_v) begin
        buf_q <= {buf_q[35:0], rx_b};
        idx_q <= idx_q + 1'b1;
        if (last) begin
          addr_q  <= op_q == OP_W ? buf_q[43:24] : {buf_q[11:0], rx_b};
          wdata_q <= op_q == OP_W ? {buf_q[23:0], rx_b} : '0;
          resp_q  <= {ACK, 32'b0};
          if (op_q == OP_G) gpio_q <= rx_b[0];
        end
      end
      if (state_q == ST_ACCESS && (MSSPREADY || to_q == TO_LAST)) begin
        resp_q <= rd_ok ? {ACK, MSSPRDATA} : {(MSSPREADY && !MSSPSLVERR) ? ACK : NAK, 32'b0};
        n_q    <= rd_ok ? 3'd5 : 3'd1;
      end
      if (state_q == ST_RESP && tx_rdy) begin
        resp_q <= {resp_q[31:0], 8'h00};
        n_q    <= n_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_final_mss_core.sv
// tb_final_mss_core: directed checks of the UART-to-APB command interpreter
module tb_final_mss_core;

  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx0 = 1'b1;
  logic        rx1 = 1'b1;
  logic        adc = 1'b0;
  logic        vref = 1'b0;
  logic        rdy_en = 1'b1;
  int          rdy_wait = 0;
  logic        slverr = 1'b0;
  logic [31:0] rdata = '0;
  logic        psel, penable, pwrite, pready, txd0, txd1, m2f_n, fab_clk, gpio;
  logic [19:0] paddr;
  logic [31:0] pwdata;

  int          n_assert = 0;
  int          n_fail = 0;
  int          setup_tot = 0;
  int          acc_tot = 0;
  int          acc_run = 0;
  logic [19:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic        cap_write = 1'b0;
  logic [7:0]  rxm [0:255];
  int          wr = 0;
  int          rd = 0;

  always #5 clk = ~clk;

  assign pready = rdy_en && penable && (acc_run == rdy_wait + 1);

  final_mss_core #(.CLK_HZ(10_000_000), .BAUD(625_000), .APB_TIMEOUT(256)) dut (
    .SYSCLK          (clk),
    .MSS_RESET       (rst),
    .MSSPSEL         (psel),
    .MSSPENABLE      (penable),
    .MSSPWRITE       (pwrite),
    .MSSPADDR        (paddr),
    .MSSPWDATA       (pwdata),
    .MSSPREADY       (pready),
    .MSSPSLVERR      (slverr),
    .MSSPRDATA       (rdata),
    .UART_0_RXD      (rx0),
    .UART_0_TXD      (txd0),
    .UART_1_RXD      (rx1),
    .UART_1_TXD      (txd1),
    .ADCDirectInput_0(adc),
    .VAREF1          (vref),
    .M2F_RESET_N     (m2f_n),
    .FAB_CLK         (fab_clk),
    .GPIO_15_OUT     (gpio)
  );

  // APB observer: phase counters and captured transfer fields
  always @(negedge clk) begin
    if (psel && !penable) setup_tot++;
    if (penable) begin
      acc_tot++;
      acc_run++;
      cap_addr  = paddr;
      cap_wdata = pwdata;
      cap_write = pwrite;
    end else acc_run = 0;
  end

  // UART_0 response decoder
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (txd0 === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = txd0;
        end
        repeat (DIV) @(negedge clk);
        rxm[wr[7:0]] = b;
        wr++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx0 = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx0 = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx0 = stop;
    repeat (DIV) @(negedge clk);
    rx0 = 1'b1;
    if (!stop) repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int t = 0;
    while (wr - rd < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, 64'(wr - rd), 64'(n));
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    b = (wr > rd) ? rxm[rd[7:0]] : 8'hxx;
    if (wr > rd) rd++;
    check(tag, b, exp);
  endtask

  initial begin
    int s0, a0, t;
    repeat (3) @(negedge clk);
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_pwrite", pwrite, 1'b0);
    check("rst_paddr", paddr, 20'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_txd0", txd0, 1'b1);
    check("rst_txd1", txd1, 1'b1);
    check("rst_gpio", gpio, 1'b0);
    check("rst_m2f", m2f_n, 1'b0);
    check("fab_clk", fab_clk, clk);
    rst = 1'b0;
    @(negedge clk);
    check("m2f_release", m2f_n, 1'b1);
    rx1 = 1'b0;
    repeat (3) @(negedge clk);
    check("loop1_low", txd1, 1'b0);
    rx1 = 1'b1;
    repeat (3) @(negedge clk);
    check("loop1_high", txd1, 1'b1);
    repeat (2 * DIV) @(negedge clk);

    // write with two wait states
    rdy_wait = 2;
    s0 = setup_tot;
    a0 = acc_tot;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'h04);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    wait_rx("w_resp_cnt", 1, 40 * DIV);
    expect_byte("w_ack", 8'h06);
    check("w_addr", cap_addr, 20'h01004);
    check("w_wdata", cap_wdata, 32'hDEADBEEF);
    check("w_write", cap_write, 1'b1);
    check("w_setup_cycles", 64'(setup_tot - s0), 64'd1);
    check("w_access_cycles", 64'(acc_tot - a0), 64'd3);
    check("w_idle_psel", psel, 1'b0);
    check("w_idle_paddr", paddr, 20'h0);
    check("w_idle_pwdata", pwdata, 32'h0);

    // read, zero wait states
    rdy_wait = 0;
    rdata = 32'h12345678;
    a0 = acc_tot;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
    wait_rx("r_resp_cnt", 5, 80 * DIV);
    expect_byte("r_ack", 8'h06);
    expect_byte("r_d3", 8'h12);
    expect_byte("r_d2", 8'h34);
    expect_byte("r_d1", 8'h56);
    expect_byte("r_d0", 8'h78);
    check("r_addr", cap_addr, 20'h00008);
    check("r_write", cap_write, 1'b0);
    check("r_access_cycles", 64'(acc_tot - a0), 64'd1);

    // break on both UARTs with PREADY stuck low
    rdy_en = 1'b0;
    s0 = setup_tot;
    rx0 = 1'b0;
    rx1 = 1'b0;
    repeat (30 * DIV) @(negedge clk);
    check("brk_no_setup", 64'(setup_tot - s0), 64'd0);
    check("brk_no_resp", 64'(wr - rd), 64'd0);
    check("brk_txd0", txd0, 1'b1);
    check("brk_loop1", txd1, 1'b0);
    rx0 = 1'b1;
    rx1 = 1'b1;
    repeat (2 * DIV) @(negedge clk);

    // write that times out
    a0 = acc_tot;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_rx("to_resp_cnt", 1, 60 * DIV);
    expect_byte("to_nak", 8'h15);
    check("to_access_cycles", 64'(acc_tot - a0), 64'd256);
    check("to_setup_cycles", 64'(setup_tot - s0), 64'd1);

    // read with slave error
    rdy_en = 1'b1;
    slverr = 1'b1;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
    wait_rx("err_resp_cnt", 1, 40 * DIV);
    repeat (15 * DIV) @(negedge clk);
    check("err_single_byte", 64'(wr - rd), 64'd1);
    expect_byte("err_nak", 8'h15);
    slverr = 1'b0;

    // GPIO and ADC commands
    send_byte(8'h47); send_byte(8'h01);
    wait_rx("g_resp_cnt", 1, 40 * DIV);
    expect_byte("g_ack", 8'h06);
    check("g_gpio", gpio, 1'b1);
    adc = 1'b1;
    send_byte(8'h41);
    wait_rx("a1_resp_cnt", 1, 40 * DIV);
    expect_byte("a1_val", 8'h01);
    adc = 1'b0;
    send_byte(8'h41);
    wait_rx("a0_resp_cnt", 1, 40 * DIV);
    expect_byte("a0_val", 8'h00);

    // reset during ACCESS
    rdy_en = 1'b0;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    t = 0;
    while (penable !== 1'b1 && t < 4 * DIV) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    check("mid_in_access", penable, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_psel", psel, 1'b0);
    check("mid_rst_penable", penable, 1'b0);
    check("mid_rst_m2f", m2f_n, 1'b0);
    check("mid_rst_txd0", txd0, 1'b1);
    rst = 1'b0;
    rdy_en = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_m2f_back", m2f_n, 1'b1);

    // reset while a response byte is on the wire
    send_byte(8'h47); send_byte(8'h01);
    t = 0;
    while (txd0 !== 1'b0 && t < 40 * DIV) begin
      @(negedge clk);
      t++;
    end
    check("abort_tx_started", txd0, 1'b0);
    repeat (DIV / 2 + 4 * DIV) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_txd0", txd0, 1'b1);
    check("abort_gpio", gpio, 1'b0);
    rst = 1'b0;
    repeat (12 * DIV) @(negedge clk);
    rd = wr;

    // bad stop bit, unknown opcode
    send_byte(8'h41, 1'b0);
    repeat (12 * DIV) @(negedge clk);
    check("badstop_no_resp", 64'(wr - rd), 64'd0);
    send_byte(8'h00);
    repeat (12 * DIV) @(negedge clk);
    check("op00_no_resp", 64'(wr - rd), 64'd0);

    // inter-byte gap abandons a partial read frame
    adc = 1'b1;
    s0 = setup_tot;
    send_byte(8'h52); send_byte(8'h00);
    repeat (20 * DIV) @(negedge clk);
    send_byte(8'h41);
    wait_rx("gap_resp_cnt", 1, 40 * DIV);
    expect_byte("gap_a_val", 8'h01);
    check("gap_no_setup", 64'(setup_tot - s0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
